bb_frame_builder: RTL and testbench
===================================

BB_FRAME_BUILDER -- requirements
Module: bb_frame_builder

Interface
REQ-001 SHALL have one clock and a synchronous active-low reset; ports are listed below, clock and reset first.
REQ-002 DCLK_IN  in  1  sole clock, rising edge.
REQ-003 RST  in  1  synchronous active-low reset.
REQ-004 FRAME_REQ  in  1  one-cycle request to build one BBFRAME.
REQ-005 DFL_BYTES  in  13  data-field length in bytes, sampled with an accepted FRAME_REQ.
REQ-006 nm_or_hem  in  1  mode, 1=HEM, 0=NM; sampled with an accepted FRAME_REQ.
REQ-007 SYNC_FOUND  in  1  TS lock from the input TS prepare stage.
REQ-008 EMPTY  in  1  input TS FIFO empty.
REQ-009 FIFO_DATA  in  8  input TS FIFO q; valid the cycle after RD_REQ, normal (non-show-ahead) FIFO.
REQ-010 FIFO_INDEX  in  8  byte index paired with FIFO_DATA.
REQ-011 RD_REQ  out  1  input TS FIFO read strobe.
REQ-012 DATA_OUT  out  8  BBFRAME byte.
REQ-013 DVALID_OUT  out  1  DATA_OUT qualifier.
REQ-014 FRAME_START  out  1  high with header byte 0.
REQ-015 FRAME_END  out  1  high with the last data-field byte.
REQ-016 BUSY  out  1  high whenever the state is not IDLE.
REQ-017 PAD_ERR  out  1  one-cycle pulse when padding starts.

Function
REQ-018 States SHALL be IDLE, PREFETCH, CAPTURE, HEADER, DATA and PAD.
REQ-019 IDLE: FRAME_REQ is ignored when DFL_BYTES=0; otherwise it latches DFL (values >6720 clamp to 6720) and mode, then moves to PREFETCH; FRAME_REQ is ignored while BUSY.
REQ-020 PREFETCH: RD_REQ=1 for one cycle when !EMPTY && SYNC_FOUND, then CAPTURE; otherwise wait.
REQ-021 CAPTURE: latch FIFO_DATA/FIFO_INDEX as first data byte, compute SYNCD, then HEADER.
REQ-022 SYNCD, for k=FIFO_INDEX and r=189-k:
- 0 if k==1 (NM) or k==2 (HEM);
- else 0xFFFF if k outside valid range (NM 1..188, HEM 2..188) or r>=DFL;
- else r*8 (16 bit).
REQ-023 HEADER SHALL emit 10 bytes, one per cycle, in order:
- 0xF0, 0x00;
- UPL {0x05,0xE0} in NM, {0x00,0x00} in HEM;
- DFL*8 MSB first;
- SYNC 0x47 in NM, 0x00 in HEM;
- SYNCD MSB first;
- CRC byte.
REQ-024 CRC byte SHALL be CRC-8 (polynomial 0xD5, init 0x00, MSB first) over header bytes 0..8, XOR 0x00 in NM or 0x01 in HEM.
REQ-025 DATA SHALL emit the prefetched byte first, then DFL-1 further FIFO bytes in order.
REQ-026 DATA SHALL assert RD_REQ only when !EMPTY and reads issued < DFL-1.
REQ-027 In DATA, a byte read with RD_REQ at cycle r SHALL appear at r+2; gaps are allowed on EMPTY; no byte is dropped or duplicated.
REQ-028 All outputs except RD_REQ SHALL be registered.
REQ-029 FRAME_END SHALL assert with data byte DFL, and the state then returns to IDLE next cycle.
REQ-030 SYNC_FOUND low in HEADER/DATA SHALL pulse PAD_ERR and move to PAD once the header completes.
REQ-031 PAD SHALL emit 0x00 at one byte per cycle, counting bytes already delivered plus in-flight reads, until DFL is reached, then assert FRAME_END.
REQ-032 In PAD, RD_REQ SHALL be 0.
REQ-033 SYNC_FOUND low in PREFETCH SHALL keep the block waiting.
REQ-034 DVALID_OUT=1 SHALL hold for every header, data and pad byte; frame length is always exactly 10+DFL valid bytes.

Reset
REQ-035 RST=0 at a clock edge SHALL force IDLE, clear counters and in-flight read tracking, and zero DATA_OUT, DVALID_OUT, RD_REQ, FRAME_START, FRAME_END, BUSY and PAD_ERR.
REQ-036 Reset mid-frame SHALL abandon the frame with no FRAME_END.

Verification
REQ-037 NM, DFL=4, first index 1, FIFO always ready -> header F0 00 05 E0 00 20 47 00 00 CRC; 4 data bytes; FRAME_END on the 14th valid byte.
REQ-038 NM, DFL=200, first index 100 -> SYNCD bytes 02 C8.
REQ-039 NM, DFL=50, first index 100 -> SYNCD FF FF.
REQ-040 HEM, DFL=4, first index 2 -> UPL 00 00, SYNC 00, SYNCD 00 00, CRC byte = CRC-8 XOR 0x01.
REQ-041 DFL=8, SYNC_FOUND falls after 3 data bytes -> PAD_ERR pulse, 5 bytes of 0x00, FRAME_END on the 18th valid byte; EMPTY toggling every cycle in DATA gives gaps only, with data intact.
REQ-042 RST=0 in DATA -> all outputs 0 next cycle; a new FRAME_REQ then yields a complete, correct frame.

Source files
------------

// File: rtl/bb_frame_builder.sv
// BBFRAME builder: emits a 10-byte header, then DFL data-field bytes read from the TS FIFO.
// If TS lock is lost mid-frame, the rest of the data field is filled with zero bytes.
module bb_frame_builder (
  input  logic        DCLK_IN,
  input  logic        RST,
  input  logic        FRAME_REQ,
  input  logic [12:0] DFL_BYTES,
  input  logic        nm_or_hem,
  input  logic        SYNC_FOUND,
  input  logic        EMPTY,
  input  logic [7:0]  FIFO_DATA,
  input  logic [7:0]  FIFO_INDEX,
  output logic        RD_REQ,
  output logic [7:0]  DATA_OUT,
  output logic        DVALID_OUT,
  output logic        FRAME_START,
  output logic        FRAME_END,
  output logic        BUSY,
  output logic        PAD_ERR
);

  typedef enum logic [2:0] {IDLE, PREFETCH, CAPTURE, HEADER, DATA, PAD} state_t;

  localparam logic [12:0] DFL_MAX = 13'd6720;

  state_t      state_q, state_d;
  logic [12:0] dfl_q, dfl_d;
  logic        hem_q, hem_d;
  logic [7:0]  first_q, first_d;
  logic [15:0] syncd_q, syncd_d;
  logic [7:0]  crc_q, crc_d;
  logic [3:0]  hdrCnt_q, hdrCnt_d;
  logic [12:0] rdCnt_q, rdCnt_d;
  logic [12:0] outCnt_q, outCnt_d;
  logic        firstSent_q, firstSent_d;
  logic        padPend_q, padPend_d;
  logic        rdPend_q;
  logic        rdReq;
  logic        emit;
  logic [7:0]  hdrByte;
  logic [15:0] dfl8;
  logic [7:0]  dout_d;
  logic        dval_d, fstart_d, fend_d, padErr_d;

  function automatic logic [7:0] crc8Byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'hD5) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Distance in bytes from the first data byte to the next TS sync byte, times 8.
  function automatic logic [15:0] calcSyncd(input logic [7:0] k, input logic hem,
                                            input logic [12:0] dfl);
    logic [7:0] r;
    logic [7:0] kMin;
    r    = 8'd189 - k;
    kMin = hem ? 8'd2 : 8'd1;
    if (k == kMin) begin
      return 16'h0000;
    end else if ((k < kMin) || (k > 8'd188) || ({5'd0, r} >= dfl)) begin
      return 16'hFFFF;
    end else begin
      return {5'd0, r, 3'b000};
    end
  endfunction

  assign dfl8 = {dfl_q, 3'b000};

  always_comb begin
    hdrByte = 8'h00;
    case (hdrCnt_q)
      4'd0:    hdrByte = 8'hF0;
      4'd1:    hdrByte = 8'h00;
      4'd2:    hdrByte = hem_q ? 8'h00 : 8'h05;
      4'd3:    hdrByte = hem_q ? 8'h00 : 8'hE0;
      4'd4:    hdrByte = dfl8[15:8];
      4'd5:    hdrByte = dfl8[7:0];
      4'd6:    hdrByte = hem_q ? 8'h00 : 8'h47;
      4'd7:    hdrByte = syncd_q[15:8];
      4'd8:    hdrByte = syncd_q[7:0];
      default: hdrByte = crc_q ^ {7'd0, hem_q};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dfl_d       = dfl_q;
    hem_d       = hem_q;
    first_d     = first_q;
    syncd_d     = syncd_q;
    crc_d       = crc_q;
    hdrCnt_d    = hdrCnt_q;
    rdCnt_d     = rdCnt_q;
    outCnt_d    = outCnt_q;
    firstSent_d = firstSent_q;
    padPend_d   = padPend_q;
    rdReq       = 1'b0;
    emit        = 1'b0;
    dout_d      = 8'h00;
    dval_d      = 1'b0;
    fstart_d    = 1'b0;
    fend_d      = 1'b0;
    padErr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (FRAME_REQ && (DFL_BYTES != 13'd0)) begin
          dfl_d   = (DFL_BYTES > DFL_MAX) ? DFL_MAX : DFL_BYTES;
          hem_d   = nm_or_hem;
          state_d = PREFETCH;
        end
      end
      PREFETCH: begin
        if (!EMPTY && SYNC_FOUND) begin
          rdReq   = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        first_d     = FIFO_DATA;
        syncd_d     = calcSyncd(FIFO_INDEX, hem_q, dfl_q);
        crc_d       = 8'h00;
        hdrCnt_d    = 4'd0;
        rdCnt_d     = 13'd0;
        outCnt_d    = 13'd0;
        firstSent_d = 1'b0;
        padPend_d   = 1'b0;
        state_d     = HEADER;
      end
      HEADER: begin
        dout_d   = hdrByte;
        dval_d   = 1'b1;
        fstart_d = (hdrCnt_q == 4'd0);
        crc_d    = crc8Byte(crc_q, hdrByte);
        hdrCnt_d = hdrCnt_q + 4'd1;
        if (!SYNC_FOUND) padPend_d = 1'b1;
        if (hdrCnt_q == 4'd9) begin
          if (padPend_q || !SYNC_FOUND) begin
            state_d  = PAD;
            padErr_d = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        // Reads stop as soon as lock drops, so nothing is in flight when PAD starts.
        emit = !firstSent_q || rdPend_q;
        if (!firstSent_q) begin
          dout_d      = first_q;
          firstSent_d = 1'b1;
        end else if (rdPend_q) begin
          dout_d = FIFO_DATA;
        end
        dval_d = emit;
        if (emit) outCnt_d = outCnt_q + 13'd1;
        if (!EMPTY && SYNC_FOUND && (rdCnt_q < (dfl_q - 13'd1))) begin
          rdReq   = 1'b1;
          rdCnt_d = rdCnt_q + 13'd1;
        end
        if (emit && ((outCnt_q + 13'd1) == dfl_q)) begin
          fend_d  = 1'b1;
          state_d = IDLE;
        end else if (!SYNC_FOUND) begin
          state_d  = PAD;
          padErr_d = 1'b1;
        end
      end
      PAD: begin
        dout_d   = 8'h00;
        dval_d   = 1'b1;
        outCnt_d = outCnt_q + 13'd1;
        if ((outCnt_q + 13'd1) == dfl_q) begin
          fend_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign RD_REQ = rdReq & RST;

  always_ff @(posedge DCLK_IN) begin
    if (!RST) begin
      state_q     <= IDLE;
      dfl_q       <= 13'd0;
      hem_q       <= 1'b0;
      first_q     <= 8'h00;
      syncd_q     <= 16'h0000;
      crc_q       <= 8'h00;
      hdrCnt_q    <= 4'd0;
      rdCnt_q     <= 13'd0;
      outCnt_q    <= 13'd0;
      firstSent_q <= 1'b0;
      padPend_q   <= 1'b0;
      rdPend_q    <= 1'b0;
      DATA_OUT    <= 8'h00;
      DVALID_OUT  <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_END   <= 1'b0;
      BUSY        <= 1'b0;
      PAD_ERR     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dfl_q       <= dfl_d;
      hem_q       <= hem_d;
      first_q     <= first_d;
      syncd_q     <= syncd_d;
      crc_q       <= crc_d;
      hdrCnt_q    <= hdrCnt_d;
      rdCnt_q     <= rdCnt_d;
      outCnt_q    <= outCnt_d;
      firstSent_q <= firstSent_d;
      padPend_q   <= padPend_d;
      rdPend_q    <= rdReq;
      DATA_OUT    <= dout_d;
      DVALID_OUT  <= dval_d;
      FRAME_START <= fstart_d;
      FRAME_END   <= fend_d;
      BUSY        <= (state_d != IDLE);
      PAD_ERR     <= padErr_d;
    end
  end

endmodule

// File: tb/tb_bb_frame_builder.sv
// Scoreboard bench for bb_frame_builder: stimulus queues the expected frame bytes,
// a monitor pops and compares each valid output byte.
module tb_bb_frame_builder;

  logic        DCLK_IN = 1'b0;
  logic        RST;
  logic        FRAME_REQ;
  logic [12:0] DFL_BYTES;
  logic        nm_or_hem;
  logic        SYNC_FOUND;
  logic        EMPTY;
  logic [7:0]  FIFO_DATA = 8'h00;
  logic [7:0]  FIFO_INDEX = 8'h00;
  logic        RD_REQ;
  logic [7:0]  DATA_OUT;
  logic        DVALID_OUT;
  logic        FRAME_START;
  logic        FRAME_END;
  logic        BUSY;
  logic        PAD_ERR;

  typedef struct {
    logic [7:0] data;
    logic       start;
    logic       last;
  } sbItem_t;

  sbItem_t    sbQ[$];
  int         compared = 0;
  int         mismatched = 0;
  int         padErrSeen = 0;
  logic       monEn = 1'b1;
  int         fifoPtr = 0;
  logic [7:0] firstIdx = 8'd1;
  logic       emptyToggle = 1'b0;
  logic       tick = 1'b0;

  bb_frame_builder dut (
    .DCLK_IN    (DCLK_IN),
    .RST        (RST),
    .FRAME_REQ  (FRAME_REQ),
    .DFL_BYTES  (DFL_BYTES),
    .nm_or_hem  (nm_or_hem),
    .SYNC_FOUND (SYNC_FOUND),
    .EMPTY      (EMPTY),
    .FIFO_DATA  (FIFO_DATA),
    .FIFO_INDEX (FIFO_INDEX),
    .RD_REQ     (RD_REQ),
    .DATA_OUT   (DATA_OUT),
    .DVALID_OUT (DVALID_OUT),
    .FRAME_START(FRAME_START),
    .FRAME_END  (FRAME_END),
    .BUSY       (BUSY),
    .PAD_ERR    (PAD_ERR)
  );

  always #5 DCLK_IN = ~DCLK_IN;

  function automatic logic [7:0] dataOf(input int n);
    return 8'((n * 37 + 11) & 255);
  endfunction

  // Bit-serial CRC-8, polynomial 0xD5, over 72 header bits MSB first.
  function automatic logic [7:0] crcModel(input logic [71:0] bits);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 71; i >= 0; i--) begin
      fb = c[7] ^ bits[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'hD5;
    end
    return c;
  endfunction

  // Normal (non-show-ahead) FIFO: data appears the cycle after the read strobe.
  always @(posedge DCLK_IN) begin
    if (RD_REQ === 1'b1) begin
      FIFO_DATA  <= dataOf(fifoPtr);
      FIFO_INDEX <= firstIdx;
      fifoPtr    <= fifoPtr + 1;
    end
  end

  always @(negedge DCLK_IN) tick = ~tick;
  assign EMPTY = emptyToggle & tick;

  task automatic monitorLoop();
    sbItem_t e;
    forever begin
      @(negedge DCLK_IN);
      if (PAD_ERR === 1'b1) padErrSeen++;
      if (monEn && (DVALID_OUT === 1'b1)) begin
        compared++;
        if (sbQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL unexpected_byte got data=%02h start=%b end=%b, none required",
                   DATA_OUT, FRAME_START, FRAME_END);
        end else begin
          e = sbQ.pop_front();
          if ((DATA_OUT !== e.data) || (FRAME_START !== e.start) || (FRAME_END !== e.last)) begin
            mismatched++;
            $display("[TB] FAIL frame_byte got data=%02h start=%b end=%b, required data=%02h start=%b end=%b",
                     DATA_OUT, FRAME_START, FRAME_END, e.data, e.start, e.last);
          end
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input int dflReq, input int dflEff, input logic hem,
                               input logic [7:0] idx, input logic [15:0] syncd,
                               input int keepData, input int syncDropAt,
                               input logic emptyTog, input int expPadErr, input logic midReq);
    logic [7:0]  hdr [10];
    logic [15:0] dfl8;
    int          base;
    int          padBase;
    int          n;
    bit          hit;
    @(negedge DCLK_IN);
    firstIdx    = idx;
    emptyToggle = emptyTog;
    base        = fifoPtr;
    padBase     = padErrSeen;
    dfl8        = 16'(dflEff * 8);
    hdr[0] = 8'hF0;
    hdr[1] = 8'h00;
    hdr[2] = hem ? 8'h00 : 8'h05;
    hdr[3] = hem ? 8'h00 : 8'hE0;
    hdr[4] = dfl8[15:8];
    hdr[5] = dfl8[7:0];
    hdr[6] = hem ? 8'h00 : 8'h47;
    hdr[7] = syncd[15:8];
    hdr[8] = syncd[7:0];
    hdr[9] = crcModel({hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], hdr[5], hdr[6], hdr[7], hdr[8]})
             ^ {7'd0, hem};
    for (int i = 0; i < 10; i++) sbQ.push_back('{data: hdr[i], start: (i == 0), last: 1'b0});
    for (int i = 0; i < dflEff; i++) begin
      sbQ.push_back('{data: (i < keepData) ? dataOf(base + i) : 8'h00,
                      start: 1'b0, last: (i == dflEff - 1)});
    end
    FRAME_REQ = 1'b1;
    DFL_BYTES = 13'(dflReq);
    nm_or_hem = hem;
    @(negedge DCLK_IN);
    FRAME_REQ = 1'b0;
    if (syncDropAt > 0) begin
      n   = 0;
      hit = 0;
      for (int c = 0; c < 1000 && !hit; c++) begin
        @(negedge DCLK_IN);
        if (DVALID_OUT === 1'b1) n++;
        if (n == syncDropAt) hit = 1;
      end
      if (!hit) checkOutput("sync_drop_timeout", 32'(n), 32'(syncDropAt));
      SYNC_FOUND = 1'b0;
      @(negedge DCLK_IN);
      SYNC_FOUND = 1'b1;
    end
    if (midReq) begin
      repeat (30) @(negedge DCLK_IN);
      FRAME_REQ = 1'b1;
      DFL_BYTES = 13'd5;
      @(negedge DCLK_IN);
      FRAME_REQ = 1'b0;
    end
    hit = 0;
    for (int c = 0; c < dflEff * 4 + 200 && !hit; c++) begin
      @(negedge DCLK_IN);
      if ((sbQ.size() == 0) && (BUSY === 1'b0)) hit = 1;
    end
    if (!hit) checkOutput("frame_timeout_left", 32'(sbQ.size()), 32'd0);
    sbQ.delete();
    checkOutput("pad_err_pulses", 32'(padErrSeen - padBase), 32'(expPadErr));
    emptyToggle = 1'b0;
  endtask

  initial begin
    int  n;
    bit  hit;
    fork
      monitorLoop();
    join_none
    RST        = 1'b0;
    FRAME_REQ  = 1'b0;
    DFL_BYTES  = 13'd0;
    nm_or_hem  = 1'b0;
    SYNC_FOUND = 1'b1;
    repeat (3) @(negedge DCLK_IN);
    checkOutput("reset_state", {24'd0, DATA_OUT} | {25'd0, DVALID_OUT, FRAME_START, FRAME_END,
                BUSY, PAD_ERR, RD_REQ, 1'b0}, 32'd0);
    RST = 1'b1;
    @(negedge DCLK_IN);

    //             req   eff  hem  idx      syncd     keep sync tog pad mid
    applyStimulus(4,    4,    0, 8'd1,   16'h0000, 4,   0,  0, 0, 0);
    applyStimulus(200,  200,  0, 8'd100, 16'h02C8, 200, 0,  0, 0, 0);
    applyStimulus(50,   50,   0, 8'd100, 16'hFFFF, 50,  0,  0, 0, 0);
    applyStimulus(4,    4,    1, 8'd2,   16'h0000, 4,   0,  0, 0, 0);
    applyStimulus(4,    4,    0, 8'd188, 16'h0008, 4,   0,  0, 0, 0);
    applyStimulus(1,    1,    0, 8'd1,   16'h0000, 1,   0,  0, 0, 0);
    applyStimulus(8,    8,    0, 8'd1,   16'h0000, 3,   12, 0, 1, 0);
    applyStimulus(8,    8,    0, 8'd150, 16'hFFFF, 8,   0,  1, 0, 0);
    applyStimulus(3,    3,    1, 8'd1,   16'hFFFF, 0,   3,  0, 1, 0);
    applyStimulus(8000, 6720, 0, 8'd50,  16'h0458, 6720, 0, 0, 0, 1);

    @(negedge DCLK_IN);
    FRAME_REQ = 1'b1;
    DFL_BYTES = 13'd0;
    @(negedge DCLK_IN);
    FRAME_REQ = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checkOutput("busy_after_dfl0", 32'(BUSY), 32'd0);
      @(negedge DCLK_IN);
    end

    monEn     = 1'b0;
    firstIdx  = 8'd1;
    FRAME_REQ = 1'b1;
    DFL_BYTES = 13'd20;
    nm_or_hem = 1'b0;
    @(negedge DCLK_IN);
    FRAME_REQ = 1'b0;
    n   = 0;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge DCLK_IN);
      if (DVALID_OUT === 1'b1) n++;
      if (n == 13) hit = 1;
    end
    checkOutput("reached_data_before_reset", 32'(n), 32'd13);
    RST = 1'b0;
    @(negedge DCLK_IN);
    checkOutput("midframe_reset_outputs", {24'd0, DATA_OUT} | {25'd0, DVALID_OUT, FRAME_START,
                FRAME_END, BUSY, PAD_ERR, RD_REQ, 1'b0}, 32'd0);
    RST   = 1'b1;
    monEn = 1'b1;
    applyStimulus(6,    6,    0, 8'd5,   16'hFFFF, 6,   0,  0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL global_timeout reached without completing the run");
    $fatal(1, "[TB] global timeout");
  end

endmodule
